// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared definitions for the BIP control unit: field widths,
//               opcode values, FSM state encoding and accumulator source
//               select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

    // Field widths of the 16-bit instruction word and the control unit state
    localparam int c_PC_WIDTH      = 11;
    localparam int c_OPCODE_WIDTH  = 5;
    localparam int c_OPERAND_WIDTH = 11;
    localparam int c_INSTR_WIDTH   = c_OPCODE_WIDTH + c_OPERAND_WIDTH;
    localparam int c_CNT_WIDTH     = 32;

    // Opcodes, instruction[15:11]; everything from 5'b01000 upwards is a NOP
    localparam logic [c_OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
    localparam logic [c_OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

    // Control FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Accumulator source select
    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/bip_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bip_instruction_decoder
// Description : Purely combinational opcode decoder. Maps the 5-bit opcode to
//               the datapath control bits; unknown opcodes decode as NOP.
// Ports       : i_opcode     in  5  instruction[15:11]
//               o_sel_a      out 2  accumulator source
//               o_sel_b      out 1  ALU B source (1 = immediate, 0 = memory)
//               o_operation  out 1  0 add, 1 subtract
//               o_write_acc  out 1  accumulator write enable
//               o_wr_ram     out 1  data memory write
//               o_rd_ram     out 1  data memory read
//               o_is_halt    out 1  opcode is HLT
// Revision    : 1.0 - initial release
// ============================================================================
module bip_instruction_decoder
    import bip_pkg::*;
(
    input  logic [c_OPCODE_WIDTH-1:0] i_opcode,
    output logic [1:0]                o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_operation,
    output logic                      o_write_acc,
    output logic                      o_wr_ram,
    output logic                      o_rd_ram,
    output logic                      o_is_halt
);

    always_comb begin
        o_sel_a     = SEL_A_MEM;
        o_sel_b     = 1'b0;
        o_operation = 1'b0;
        o_write_acc = 1'b0;
        o_wr_ram    = 1'b0;
        o_rd_ram    = 1'b0;
        o_is_halt   = 1'b0;
        case (i_opcode)
            OP_HLT: o_is_halt = 1'b1;
            OP_STO: o_wr_ram  = 1'b1;
            OP_LD: begin
                o_sel_a     = SEL_A_MEM;
                o_write_acc = 1'b1;
                o_rd_ram    = 1'b1;
            end
            OP_LDI: begin
                o_sel_a     = SEL_A_IMM;
                o_write_acc = 1'b1;
            end
            OP_ADD: begin
                o_sel_a     = SEL_A_ALU;
                o_write_acc = 1'b1;
                o_rd_ram    = 1'b1;
            end
            OP_ADDI: begin
                o_sel_a     = SEL_A_ALU;
                o_sel_b     = 1'b1;
                o_write_acc = 1'b1;
            end
            OP_SUB: begin
                o_sel_a     = SEL_A_ALU;
                o_operation = 1'b1;
                o_write_acc = 1'b1;
                o_rd_ram    = 1'b1;
            end
            OP_SUBI: begin
                o_sel_a     = SEL_A_ALU;
                o_sel_b     = 1'b1;
                o_operation = 1'b1;
                o_write_acc = 1'b1;
            end
            default: ; // NOP: all controls stay inactive
        endcase
    end

endmodule : bip_instruction_decoder
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : bip_control_unit
// Description : BIP core control unit. Holds the PC, sequences FETCH/EXEC for
//               each instruction until HLT, decodes the instruction word into
//               datapath controls and counts the active (FETCH+EXEC) cycles.
// Ports       : clk            in   1  clock, posedge
//               rst            in   1  synchronous active-high reset
//               i_start        in   1  level; leaves IDLE when 1
//               i_instruction  in  16  program memory read data (valid in EXEC)
//               o_pc           out 11  program memory address
//               o_operand      out 11  operand / data memory address
//               o_sel_a        out  2  accumulator source
//               o_sel_b        out  1  ALU B source
//               o_write_acc    out  1  accumulator write enable
//               o_operation    out  1  0 add, 1 subtract
//               o_wr_ram       out  1  data memory write strobe
//               o_rd_ram       out  1  data memory read strobe
//               o_halted       out  1  1 while in HALT
//               o_cycle_count  out 32  saturating FETCH+EXEC cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int PC_WIDTH      = c_PC_WIDTH,
    parameter int OPCODE_WIDTH  = c_OPCODE_WIDTH,
    parameter int OPERAND_WIDTH = c_OPERAND_WIDTH,
    parameter int INSTR_WIDTH   = c_INSTR_WIDTH,
    parameter int CNT_WIDTH     = c_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [INSTR_WIDTH-1:0]   i_instruction,
    output logic [PC_WIDTH-1:0]      o_pc,
    output logic [OPERAND_WIDTH-1:0] o_operand,
    output logic [1:0]               o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_write_acc,
    output logic                     o_operation,
    output logic                     o_wr_ram,
    output logic                     o_rd_ram,
    output logic                     o_halted,
    output logic [CNT_WIDTH-1:0]     o_cycle_count
);

    logic [1:0]           r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_halted;

    logic [1:0] w_dec_sel_a;
    logic       w_dec_sel_b;
    logic       w_dec_operation;
    logic       w_dec_write_acc;
    logic       w_dec_wr_ram;
    logic       w_dec_rd_ram;
    logic       w_is_halt;
    logic       w_exec;
    logic       w_active;

    bip_instruction_decoder u_decoder (
        .i_opcode    (i_instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH]),
        .o_sel_a     (w_dec_sel_a),
        .o_sel_b     (w_dec_sel_b),
        .o_operation (w_dec_operation),
        .o_write_acc (w_dec_write_acc),
        .o_wr_ram    (w_dec_wr_ram),
        .o_rd_ram    (w_dec_rd_ram),
        .o_is_halt   (w_is_halt)
    );

    assign w_exec   = (r_state == ST_EXEC);
    assign w_active = (r_state == ST_FETCH) || w_exec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            // Saturate rather than wrap so a very long run never reports a
            // misleadingly small count.
            if (w_active && (r_count != {CNT_WIDTH{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_is_halt) begin
                        // PC is left pointing at the HLT word
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + 1'b1;   // wraps naturally at PC_WIDTH
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;           // only rst leaves HALT
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded controls are only presented during EXEC, when the program
    // memory data belongs to the current PC; the datapath samples them on
    // the following negedge.
    assign o_pc          = r_pc;
    assign o_operand     = w_exec ? i_instruction[OPERAND_WIDTH-1:0] : '0;
    assign o_sel_a       = w_exec ? w_dec_sel_a : SEL_A_MEM;
    assign o_sel_b       = w_exec & w_dec_sel_b;
    assign o_operation   = w_exec & w_dec_operation;
    assign o_write_acc   = w_exec & w_dec_write_acc;
    assign o_wr_ram      = w_exec & w_dec_wr_ram;
    assign o_rd_ram      = w_exec & w_dec_rd_ram;
    assign o_halted      = r_halted;
    assign o_cycle_count = r_count;

endmodule : bip_control_unit
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_control_unit
// Description : Self-checking bench for bip_control_unit with a synchronous
//               program ROM model, an instruction/decode vector table and a
//               per-cycle expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_instruction;
    logic [10:0] o_pc;
    logic [10:0] o_operand;
    logic [1:0]  o_sel_a;
    logic        o_sel_b;
    logic        o_write_acc;
    logic        o_operation;
    logic        o_wr_ram;
    logic        o_rd_ram;
    logic        o_halted;
    logic [31:0] o_cycle_count;

    bip_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .o_pc          (o_pc),
        .o_operand     (o_operand),
        .o_sel_a       (o_sel_a),
        .o_sel_b       (o_sel_b),
        .o_write_acc   (o_write_acc),
        .o_operation   (o_operation),
        .o_wr_ram      (o_wr_ram),
        .o_rd_ram      (o_rd_ram),
        .o_halted      (o_halted),
        .o_cycle_count (o_cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory
    logic [15:0] rom [0:2047];
    always @(posedge clk) i_instruction <= rom[o_pc];

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        wacc;
        logic        wr;
        logic        rd;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] pc;
        logic [10:0] operand;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        wacc;
        logic        wr;
        logic        rd;
        logic        halted;
        logic [31:0] count;
    } exp_t;

    vec_t prog [0:2047];
    vec_t table_v [0:10];
    vec_t nop_v;
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk_quiet(string name, logic [10:0] pc, logic [31:0] cnt, logic halted);
        exp_t e;
        e.name = name; e.pc = pc; e.operand = '0; e.sel_a = 2'd0; e.sel_b = 1'b0;
        e.op = 1'b0; e.wacc = 1'b0; e.wr = 1'b0; e.rd = 1'b0; e.halted = halted; e.count = cnt;
        return e;
    endfunction

    function automatic exp_t mk_exec(logic [10:0] pc, logic [31:0] cnt, vec_t v);
        exp_t e;
        e.name = {"exec_", v.name}; e.pc = pc; e.operand = v.instr[10:0]; e.sel_a = v.sel_a;
        e.sel_b = v.sel_b; e.op = v.op; e.wacc = v.wacc; e.wr = v.wr; e.rd = v.rd;
        e.halted = 1'b0; e.count = cnt;
        return e;
    endfunction

    task automatic check(input exp_t e);
        checks++;
        if ({o_pc, o_operand, o_sel_a, o_sel_b, o_operation, o_write_acc, o_wr_ram, o_rd_ram,
             o_halted, o_cycle_count} !==
            {e.pc, e.operand, e.sel_a, e.sel_b, e.op, e.wacc, e.wr, e.rd, e.halted, e.count}) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got pc=%h opnd=%h sa=%0d sb=%b op=%b wacc=%b wr=%b rd=%b halt=%b cnt=%0d; want pc=%h opnd=%h sa=%0d sb=%b op=%b wacc=%b wr=%b rd=%b halt=%b cnt=%0d",
                         e.name, o_pc, o_operand, o_sel_a, o_sel_b, o_operation, o_write_acc,
                         o_wr_ram, o_rd_ram, o_halted, o_cycle_count, e.pc, e.operand, e.sel_a,
                         e.sel_b, e.op, e.wacc, e.wr, e.rd, e.halted, e.count);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            @(negedge clk);
            check(sb.pop_front());
        end
    endtask

    task automatic load_prog(input vec_t v [], input int n);
        for (int i = 0; i < 2048; i++) begin
            prog[i] = (i < n) ? v[i] : nop_v;
            rom[i]  = prog[i].instr;
        end
    endtask

    // Three reset edges, check the reset state, release rst at posedge+1
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(mk_quiet("reset", 11'd0, 32'd0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Start the program and check every FETCH/EXEC cycle (and HALT if expected)
    task automatic run_prog(input int n, input bit halt_end, input bit hold_start);
        @(negedge clk);
        check(mk_quiet("idle", 11'd0, 32'd0, 1'b0));
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = hold_start;
        for (int k = 0; k < n; k++) begin
            sb.push_back(mk_quiet("fetch", 11'(k % 2048), 32'(2 * k), 1'b0));
            sb.push_back(mk_exec(11'(k % 2048), 32'(2 * k + 1), prog[k % 2048]));
        end
        if (halt_end)
            sb.push_back(mk_quiet("halt", 11'((n - 1) % 2048), 32'(2 * n), 1'b1));
        drain();
    endtask

    initial begin
        vec_t t2 [];
        vec_t tv [];
        rst = 1'b1; i_start = 1'b0;

        //                name     instr     sa  sb  op  wacc wr  rd
        nop_v       = '{"nop",   16'h4000, 2'd0, 0, 0, 0, 0, 0};
        table_v[0]  = '{"ldi",   16'h1805, 2'd1, 0, 0, 1, 0, 0};
        table_v[1]  = '{"addi",  16'h2803, 2'd2, 1, 0, 1, 0, 0};
        table_v[2]  = '{"sto",   16'h0810, 2'd0, 0, 0, 0, 1, 0};
        table_v[3]  = '{"ld",    16'h1123, 2'd0, 0, 0, 1, 0, 1};
        table_v[4]  = '{"add",   16'h27FF, 2'd2, 0, 0, 1, 0, 1};
        table_v[5]  = '{"sub",   16'h37FF, 2'd2, 0, 1, 1, 0, 1};
        table_v[6]  = '{"subi",  16'h3FFE, 2'd2, 1, 1, 1, 0, 0};
        table_v[7]  = '{"nop08", 16'h4000, 2'd0, 0, 0, 0, 0, 0};
        table_v[8]  = '{"nop1f", 16'hF8AB, 2'd0, 0, 0, 0, 0, 0};
        table_v[9]  = '{"nop10", 16'h8555, 2'd0, 0, 0, 0, 0, 0};
        table_v[10] = '{"hlt",   16'h0042, 2'd0, 0, 0, 0, 0, 0};

        // LDI 5, ADDI 3, STO 0x010, HLT; then i_start held high in HALT
        t2 = new[4];
        t2[0] = table_v[0]; t2[1] = table_v[1]; t2[2] = table_v[2];
        t2[3] = '{"hlt0", 16'h0000, 2'd0, 0, 0, 0, 0, 0};
        load_prog(t2, 4);
        do_reset();
        run_prog(4, 1'b1, 1'b0);
        i_start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check(mk_quiet("halt_start_held", 11'd3, 32'd8, 1'b1));
        end
        i_start = 1'b0;

        // Full decode table, i_start held high throughout FETCH/EXEC
        tv = new[11];
        foreach (tv[i]) tv[i] = table_v[i];
        load_prog(tv, 11);
        do_reset();
        run_prog(11, 1'b1, 1'b1);
        i_start = 1'b0;

        // All-NOP ROM: PC wraps 0x7FF -> 0x000, count 4096 at the wrap FETCH
        load_prog(tv, 0);
        do_reset();
        run_prog(2049, 1'b0, 1'b0);

        // rst asserted during EXEC of ADDI
        load_prog(t2, 4);
        do_reset();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk); #1;          // FETCH pc0
        i_start = 1'b0;
        @(posedge clk); #1;          // EXEC pc0
        @(posedge clk); #1;          // FETCH pc1
        @(posedge clk); #1;          // EXEC pc1 (ADDI)
        rst = 1'b1;
        @(negedge clk);
        check(mk_exec(11'd1, 32'd3, table_v[1]));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check(mk_quiet("after_rst_idle", 11'd0, 32'd0, 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bip_control_unit
`default_nettype wire
